m_sw_event: RTL and testbench

M_SW_EVENT -- requirements
Module: m_sw_event

---
 rtl/m_sw_event_if.sv | 29 ++
 rtl/m_sw_event.sv | 109 ++++++++++
 tb/tb_m_sw_event.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/m_sw_event_if.sv
// Switch event bus: debounced switch level in, event pulses and held level out.
//   master : drives sw_in, observes the event outputs (testbench / consumer side)
//   slave  : samples sw_in, drives press_p, rel_p, long_p, rep_p, held (m_sw_event side)
interface m_sw_event_if;
  logic sw_in;
  logic press_p;
  logic rel_p;
  logic long_p;
  logic rep_p;
  logic held;

  modport master (
    output sw_in,
    input  press_p,
    input  rel_p,
    input  long_p,
    input  rep_p,
    input  held
  );

  modport slave (
    input  sw_in,
    output press_p,
    output rel_p,
    output long_p,
    output rep_p,
    output held
  );
endinterface

// File: rtl/m_sw_event.sv
// Switch event detector: turns a debounced, asynchronous switch level into
// one-cycle press / release / long-press / auto-repeat pulses plus a held level.
// Ports:
//   clk   : system clock, all state on rising edge
//   rst   : synchronous active-high reset
//   sw_if : m_sw_event_if.slave (sw_in in; press_p, rel_p, long_p, rep_p, held out)
// Parameters:
//   LONG_CYC : cycles a press must last before long_p (2..2^24-1)
//   REP_CYC  : auto-repeat period after long_p (2..2^24-1)
module m_sw_event #(
  parameter logic [23:0] LONG_CYC = 24'd12000000,
  parameter logic [23:0] REP_CYC  = 24'd3000000
) (
  input logic           clk,
  input logic           rst,
  m_sw_event_if.slave   sw_if
);

  localparam int unsigned CNT_W = 24;
  localparam logic [CNT_W-1:0] LONG_LAST = LONG_CYC - CNT_W'(1);
  localparam logic [CNT_W-1:0] REP_LAST  = REP_CYC - CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state;
  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;

  // Synchronizer, FSM and registered outputs; pulses default low each cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1            <= 1'b0;
      s2            <= 1'b0;
      state         <= IDLE;
      cnt           <= '0;
      sw_if.press_p <= 1'b0;
      sw_if.rel_p   <= 1'b0;
      sw_if.long_p  <= 1'b0;
      sw_if.rep_p   <= 1'b0;
      sw_if.held    <= 1'b0;
    end else begin
      s1            <= sw_if.sw_in;
      s2            <= s1;
      sw_if.press_p <= 1'b0;
      sw_if.rel_p   <= 1'b0;
      sw_if.long_p  <= 1'b0;
      sw_if.rep_p   <= 1'b0;

      case (state)
        IDLE: begin
          cnt <= '0;
          if (s2) begin
            state         <= PRESS;
            sw_if.press_p <= 1'b1;
            sw_if.held    <= 1'b1;
          end else begin
            sw_if.held    <= 1'b0;
          end
        end

        // Release is tested first so it wins over a terminal count.
        PRESS: begin
          if (!s2) begin
            state       <= IDLE;
            sw_if.rel_p <= 1'b1;
            sw_if.held  <= 1'b0;
            cnt         <= '0;
          end else if (cnt == LONG_LAST) begin
            state        <= HOLD;
            sw_if.long_p <= 1'b1;
            sw_if.held   <= 1'b1;
            cnt          <= '0;
          end else begin
            sw_if.held <= 1'b1;
            cnt        <= cnt + CNT_W'(1);
          end
        end

        HOLD: begin
          if (!s2) begin
            state       <= IDLE;
            sw_if.rel_p <= 1'b1;
            sw_if.held  <= 1'b0;
            cnt         <= '0;
          end else if (cnt == REP_LAST) begin
            sw_if.rep_p <= 1'b1;
            sw_if.held  <= 1'b1;
            cnt         <= '0;
          end else begin
            sw_if.held <= 1'b1;
            cnt        <= cnt + CNT_W'(1);
          end
        end

        default: begin
          state      <= IDLE;
          sw_if.held <= 1'b0;
          cnt        <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_m_sw_event.sv
// Self-checking bench for m_sw_event with LONG_CYC=8, REP_CYC=4.
// Reference model: sw_in delayed two edges, then events derived from the
// number of edges elapsed since the press edge.
module tb_m_sw_event;

  localparam int LONG = 8;
  localparam int REP  = 4;

  logic clk = 1'b0;
  logic rst;

  int total = 0;
  int bad   = 0;

  m_sw_event_if bus ();

  m_sw_event #(
    .LONG_CYC (24'(LONG)),
    .REP_CYC  (24'(REP))
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .sw_if (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model state
  bit m_s1, m_s2, m_pressed;
  int m_h;
  bit e_press, e_rel, e_long, e_rep, e_held;

  task automatic model_edge(input bit r, input bit v);
    bit see;
    e_press = 0; e_rel = 0; e_long = 0; e_rep = 0;
    if (r) begin
      m_s1 = 0; m_s2 = 0; m_pressed = 0; m_h = 0;
    end else begin
      see  = m_s2;
      m_s2 = m_s1;
      m_s1 = v;
      if (!m_pressed) begin
        if (see) begin
          m_pressed = 1; m_h = 0; e_press = 1;
        end
      end else if (!see) begin
        m_pressed = 0; e_rel = 1;
      end else begin
        m_h++;
        if (m_h == LONG) e_long = 1;
        else if (m_h > LONG && ((m_h - LONG) % REP) == 0) e_rep = 1;
      end
    end
    e_held = m_pressed;
  endtask

  function automatic logic [4:0] obs_vec();
    return {bus.press_p, bus.rel_p, bus.long_p, bus.rep_p, bus.held};
  endfunction

  function automatic logic [4:0] model_vec();
    return {e_press, e_rel, e_long, e_rep, e_held};
  endfunction

  // Advance one rising edge, update the model with what the DUT sampled, settle.
  task automatic tick();
    @(posedge clk);
    model_edge(rst, bus.sw_in);
    #1;
  endtask

  task automatic settle_idle();
    bus.sw_in = 1'b0;
    rst = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.sw_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (obs_vec() !== 5'b0) begin
        bad++;
        $display("FAIL reset cyc%0d got=%b want=00000", i, obs_vec());
      end
    end
    bus.sw_in = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (obs_vec() !== 5'b0) begin
        bad++;
        $display("FAIL post_reset cyc%0d got=%b want=00000", i, obs_vec());
      end
    end
  endtask

  task automatic test_short_press();
    logic [4:0] want;
    settle_idle();
    for (int e = 0; e <= 10; e++) begin
      bus.sw_in = (e <= 4);
      tick();
      want = {e == 2, e == 7, 1'b0, 1'b0, (e >= 2 && e <= 6)};
      total++;
      if (obs_vec() !== want) begin
        bad++;
        $display("FAIL short_press E%0d got=%b want=%b", e, obs_vec(), want);
      end
      total++;
      if (obs_vec() !== model_vec()) begin
        bad++;
        $display("FAIL short_press_model E%0d got=%b want=%b", e, obs_vec(), model_vec());
      end
    end
  endtask

  task automatic test_long_hold();
    logic [4:0] want;
    settle_idle();
    for (int e = 0; e <= 25; e++) begin
      bus.sw_in = (e <= 19);
      tick();
      want = {e == 2, e == 22, e == 10, (e == 14 || e == 18), (e >= 2 && e <= 21)};
      total++;
      if (obs_vec() !== want) begin
        bad++;
        $display("FAIL long_hold E%0d got=%b want=%b", e, obs_vec(), want);
      end
      total++;
      if (obs_vec() !== model_vec()) begin
        bad++;
        $display("FAIL long_hold_model E%0d got=%b want=%b", e, obs_vec(), model_vec());
      end
    end
  endtask

  task automatic test_glitch();
    logic [4:0] want;
    settle_idle();
    for (int e = 0; e <= 6; e++) begin
      bus.sw_in = (e == 0);
      tick();
      want = {e == 2, e == 3, 1'b0, 1'b0, e == 2};
      total++;
      if (obs_vec() !== want) begin
        bad++;
        $display("FAIL glitch E%0d got=%b want=%b", e, obs_vec(), want);
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    logic [4:0] want;
    settle_idle();
    for (int e = 0; e <= 20; e++) begin
      bus.sw_in = 1'b1;
      rst = (e == 12 || e == 13);
      tick();
      want = {(e == 2 || e == 16), 1'b0, e == 10, 1'b0,
              ((e >= 2 && e <= 11) || e >= 16)};
      total++;
      if (obs_vec() !== want) begin
        bad++;
        $display("FAIL reset_mid_hold E%0d got=%b want=%b", e, obs_vec(), want);
      end
      total++;
      if (obs_vec() !== model_vec()) begin
        bad++;
        $display("FAIL reset_mid_hold_model E%0d got=%b want=%b", e, obs_vec(), model_vec());
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_random();
    int run_left = 0;
    logic [4:0] o;
    settle_idle();
    for (int i = 0; i < 10000; i++) begin
      if (run_left == 0) begin
        bus.sw_in = ~bus.sw_in;
        run_left = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 30))
                                                : int'($urandom_range(1, 4));
      end
      run_left--;
      rst = ($urandom_range(0, 499) == 0);
      tick();
      o = obs_vec();
      total++;
      if (o !== model_vec()) begin
        bad++;
        $display("FAIL random_model cyc%0d got=%b want=%b", i, o, model_vec());
      end
      total++;
      if ($countones(o[4:1]) > 1) begin
        bad++;
        $display("FAIL random_exclusive cyc%0d pulses=%b want at most one high", i, o[4:1]);
      end
      total++;
      if (dut.cnt > 24'(LONG - 1)) begin
        bad++;
        $display("FAIL random_cnt_bound cyc%0d cnt=%0d want<=%0d", i, dut.cnt, LONG - 1);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.sw_in = 1'b0;
    test_reset();
    test_short_press();
    test_long_hold();
    test_glitch();
    test_reset_mid_hold();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
